// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
package uart_arb_pkg;

  localparam int NUM_REQ                = 2;
  localparam int DATA_W                 = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BUSY,
    ACK
  } state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick between two requesters; a tie goes to the
// requester that was not granted last.
module uart_rr_pick
  import uart_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic               lastPtr,
  output logic               winIdx,
  output logic               winValid
);

  always_comb begin
    winValid = |reqVec;
    winIdx   = reqVec[1];
    if (&reqVec) winIdx = ~lastPtr;
  end

endmodule

// File: rtl/uart_xmit_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte sources.
// Optional BUSY watchdog with err pulses is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_xmit_arbiter
  import uart_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       sys_clk,
  input  logic       sys_rstH,
  input  logic       req0H,
  input  logic       req1H,
  input  logic [7:0] req0_dataH,
  input  logic [7:0] req1_dataH,
  output logic       ack0H,
  output logic       ack1H,
  output logic       err0H,
  output logic       err1H,
  output logic       xmitH,
  output logic [7:0] xmit_dataH,
  input  logic       xmit_doneH,
  output logic       busyH
);

  if (TIMEOUT_CYCLES < 2) begin : g_badTimeout
    $error("uart_xmit_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  state_e              state, nextState;
  logic                lastPtr;
  logic                winIdx;
  logic [DATA_W-1:0]   dataReg;
  logic                pickIdx, pickValid;
  logic                tmoHit;

  uart_rr_pick u_pick (
    .reqVec   ({req1H, req0H}),
    .lastPtr  (lastPtr),
    .winIdx   (pickIdx),
    .winValid (pickValid)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmoCnt;

  // A done arriving on the final BUSY cycle wins over the abort.
  assign tmoHit = (state == BUSY) && !xmit_doneH &&
                  (tmoCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rstH)           tmoCnt <= '0;
    else if (state == LOAD) tmoCnt <= '0;
    else if (state == BUSY) tmoCnt <= tmoCnt + CNT_W'(1);
  end
`else
  assign tmoHit = 1'b0;
`endif

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (pickValid) nextState = LOAD;
      LOAD:    nextState = BUSY;
      BUSY: begin
        if (xmit_doneH)  nextState = ACK;
        else if (tmoHit) nextState = IDLE;
      end
      ACK:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rstH) begin
      state   <= IDLE;
      lastPtr <= 1'b1;
      winIdx  <= 1'b0;
      dataReg <= '0;
    end else begin
      state <= nextState;
      // Data is captured only at grant, so requester-side changes later on are invisible.
      if (state == IDLE && pickValid) begin
        winIdx  <= pickIdx;
        dataReg <= pickIdx ? req1_dataH : req0_dataH;
      end
      if (state == ACK || tmoHit) lastPtr <= winIdx;
    end
  end

  assign xmitH      = (state == LOAD);
  assign busyH      = (state != IDLE);
  assign xmit_dataH = dataReg;
  assign ack0H      = (state == ACK) && !winIdx;
  assign ack1H      = (state == ACK) &&  winIdx;
  // err fires in the aborting BUSY cycle so the requester can drop before IDLE re-arbitrates.
  assign err0H      = tmoHit && !winIdx;
  assign err1H      = tmoHit &&  winIdx;

endmodule

// File: tb/tb_uart_xmit_arbiter.sv
// Scoreboard bench for uart_xmit_arbiter (TIMEOUT_CYCLES=16).
module tb_uart_xmit_arbiter;

  typedef struct packed {
    logic       idx;
    logic [7:0] data;
    logic       isErr;
    logic       good;
  } rec_t;

  logic       sys_clk, sys_rstH;
  logic       req0H, req1H, ack0H, ack1H, err0H, err1H, xmitH, xmit_doneH, busyH;
  logic [7:0] req0_dataH, req1_dataH, xmit_dataH;

  logic       autoReq, uartAuto;
  logic       aReq0, aReq1, mReq0, mReq1, aDone, mDone;
  logic [7:0] aD0, aD1, mD0, mD1;
  int         uartDelay;
  int         checks, failures;

  rec_t       expQ[$], obsQ[$];
  logic [7:0] txQ0[$], txQ1[$];

  assign req0H      = autoReq ? aReq0 : mReq0;
  assign req1H      = autoReq ? aReq1 : mReq1;
  assign req0_dataH = autoReq ? aD0 : mD0;
  assign req1_dataH = autoReq ? aD1 : mD1;
  assign xmit_doneH = aDone | mDone;

  uart_xmit_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .sys_clk    (sys_clk),
    .sys_rstH   (sys_rstH),
    .req0H      (req0H),
    .req1H      (req1H),
    .req0_dataH (req0_dataH),
    .req1_dataH (req1_dataH),
    .ack0H      (ack0H),
    .ack1H      (ack1H),
    .err0H      (err0H),
    .err1H      (err1H),
    .xmitH      (xmitH),
    .xmit_dataH (xmit_dataH),
    .xmit_doneH (xmit_doneH),
    .busyH      (busyH)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Requesters: hold until ack/err, then either re-request with the next byte or drop.
  initial begin
    aReq0 = 1'b0; aReq1 = 1'b0; aD0 = '0; aD1 = '0;
    forever begin
      tick();
      if (!autoReq) begin
        aReq0 = 1'b0; aReq1 = 1'b0;
      end else begin
        if (aReq0 && (ack0H || err0H)) begin
          if (txQ0.size() > 0) aD0 = txQ0.pop_front(); else aReq0 = 1'b0;
        end else if (!aReq0 && txQ0.size() > 0) begin
          aReq0 = 1'b1; aD0 = txQ0.pop_front();
        end
        if (aReq1 && (ack1H || err1H)) begin
          if (txQ1.size() > 0) aD1 = txQ1.pop_front(); else aReq1 = 1'b0;
        end else if (!aReq1 && txQ1.size() > 0) begin
          aReq1 = 1'b1; aD1 = txQ1.pop_front();
        end
      end
    end
  end

  // UART model: done pulse uartDelay cycles after the start pulse.
  initial begin
    aDone = 1'b0;
    forever begin
      tick();
      if (uartAuto && xmitH) begin
        repeat (uartDelay) tick();
        if (uartAuto) begin
          aDone = 1'b1;
          tick();
          aDone = 1'b0;
        end
      end
    end
  end

  // Monitor: one record per ack/err pulse with the byte seen at xmitH and its stability.
  initial begin
    rec_t       r;
    logic [7:0] curData;
    logic       curStable;
    curData = '0; curStable = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (!sys_rstH) begin
        if (xmitH) begin
          curData = xmit_dataH; curStable = 1'b1;
        end else if (busyH && xmit_dataH !== curData) begin
          curStable = 1'b0;
        end
        if (ack0H || ack1H || err0H || err1H) begin
          r.idx   = ack1H | err1H;
          r.data  = curData;
          r.isErr = err0H | err1H;
          r.good  = curStable && ($countones({ack0H, ack1H, err0H, err1H}) == 1);
          obsQ.push_back(r);
        end
      end
    end
  end

  task automatic wait_obs(input int n, input int limit, output bit ok);
    for (int c = 0; c < limit && obsQ.size() < n; c++) @(posedge sys_clk);
    #1;
    ok = (obsQ.size() >= n);
  endtask

  task automatic do_reset();
    autoReq = 1'b0; uartAuto = 1'b0; uartDelay = 3;
    mReq0 = 1'b0; mReq1 = 1'b0; mD0 = '0; mD1 = '0; mDone = 1'b0;
    txQ0.delete(); txQ1.delete(); expQ.delete();
    sys_rstH = 1'b1;
    repeat (2) tick();
    sys_rstH = 1'b0;
    obsQ.delete();
  endtask

  task automatic test_reset();
    sys_rstH = 1'b1; mReq0 = 1'b1; mD0 = 8'h5A; mDone = 1'b1;
    repeat (2) tick();
    checks++; if (xmitH !== 1'b0) begin failures++; $display("FAIL reset_xmit got %b expected 0", xmitH); end
    checks++; if (xmit_dataH !== 8'h00) begin failures++; $display("FAIL reset_data got %h expected 00", xmit_dataH); end
    checks++; if ({ack0H, ack1H} !== 2'b00) begin failures++; $display("FAIL reset_ack got %b expected 00", {ack0H, ack1H}); end
    checks++; if ({err0H, err1H} !== 2'b00) begin failures++; $display("FAIL reset_err got %b expected 00", {err0H, err1H}); end
    checks++; if (busyH !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", busyH); end
    mReq0 = 1'b0; mDone = 1'b0;
    do_reset();
  endtask

  task automatic test_single();
    rec_t e, o;
    bit   ok;
    do_reset();
    mD0 = 8'hA5; mReq0 = 1'b1;
    expQ.push_back('{1'b0, 8'hA5, 1'b0, 1'b1});
    #1;
    checks++; if ({xmitH, busyH} !== 2'b00) begin failures++; $display("FAIL single_idle got xmit/busy=%b expected 00", {xmitH, busyH}); end
    tick();
    checks++; if (xmitH !== 1'b1 || xmit_dataH !== 8'hA5) begin failures++; $display("FAIL single_xmit got xmit=%b data=%h expected 1 a5", xmitH, xmit_dataH); end
    tick();
    checks++; if (xmitH !== 1'b0 || busyH !== 1'b1) begin failures++; $display("FAIL single_busy got xmit=%b busy=%b expected 0 1", xmitH, busyH); end
    repeat (9) tick();
    mDone = 1'b1;
    tick();
    mDone = 1'b0;
    checks++; if ({ack0H, ack1H} !== 2'b10) begin failures++; $display("FAIL single_ack got %b expected 10", {ack0H, ack1H}); end
    mReq0 = 1'b0;
    tick();
    checks++; if (ack0H !== 1'b0 || busyH !== 1'b0) begin failures++; $display("FAIL single_after got ack0=%b busy=%b expected 0 0", ack0H, busyH); end
    wait_obs(1, 5, ok);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin failures++; $display("FAIL single_rec got none expected %h", e); end
      else begin o = obsQ.pop_front(); if (o !== e) begin failures++; $display("FAIL single_rec got %h expected %h", o, e); end end
    end
  endtask

  task automatic test_tie();
    rec_t e, o;
    bit   ok;
    do_reset();
    txQ0.push_back(8'h11); txQ1.push_back(8'h22);
    expQ.push_back('{1'b0, 8'h11, 1'b0, 1'b1});
    expQ.push_back('{1'b1, 8'h22, 1'b0, 1'b1});
    uartDelay = 4; uartAuto = 1'b1; autoReq = 1'b1;
    wait_obs(2, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tie_timeout got %0d records expected 2", obsQ.size()); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin failures++; $display("FAIL tie_rec got none expected %h", e); end
      else begin o = obsQ.pop_front(); if (o !== e) begin failures++; $display("FAIL tie_rec got %h expected %h", o, e); end end
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    bit   ok;
    do_reset();
    txQ0.push_back(8'hA0); txQ0.push_back(8'hA1);
    txQ1.push_back(8'hB0); txQ1.push_back(8'hB1);
    expQ.push_back('{1'b0, 8'hA0, 1'b0, 1'b1});
    expQ.push_back('{1'b1, 8'hB0, 1'b0, 1'b1});
    expQ.push_back('{1'b0, 8'hA1, 1'b0, 1'b1});
    expQ.push_back('{1'b1, 8'hB1, 1'b0, 1'b1});
    uartDelay = 2; uartAuto = 1'b1; autoReq = 1'b1;
    wait_obs(4, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL fair_timeout got %0d records expected 4", obsQ.size()); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin failures++; $display("FAIL fair_rec got none expected %h", e); end
      else begin o = obsQ.pop_front(); if (o !== e) begin failures++; $display("FAIL fair_rec got %h expected %h", o, e); end end
    end
  endtask

  task automatic test_data_change();
    rec_t e, o;
    bit   ok, seen;
    do_reset();
    uartDelay = 6; uartAuto = 1'b1;
    mD0 = 8'h5C; mReq0 = 1'b1;
    expQ.push_back('{1'b0, 8'h5C, 1'b0, 1'b1});
    tick();
    mD0 = 8'hFF; mD1 = 8'h99; mReq1 = 1'b1;
    tick();
    mReq1 = 1'b0;
    checks++; if (xmit_dataH !== 8'h5C) begin failures++; $display("FAIL chg_busy got %h expected 5c", xmit_dataH); end
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin tick(); seen = ack0H; end
    checks++; if (!seen || xmit_dataH !== 8'h5C) begin failures++; $display("FAIL chg_ack got ack=%b data=%h expected 1 5c", seen, xmit_dataH); end
    mReq0 = 1'b0;
    repeat (5) tick();
    checks++; if (busyH !== 1'b0) begin failures++; $display("FAIL chg_dropped got busy=%b expected 0", busyH); end
    wait_obs(1, 5, ok);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin failures++; $display("FAIL chg_rec got none expected %h", e); end
      else begin o = obsQ.pop_front(); if (o !== e) begin failures++; $display("FAIL chg_rec got %h expected %h", o, e); end end
    end
    checks++; if (obsQ.size() != 0) begin failures++; $display("FAIL chg_extra got %0d records expected 0", obsQ.size()); end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    mD0 = 8'h77; mReq0 = 1'b1;
    repeat (5) tick();
    checks++; if (busyH !== 1'b1 || xmit_dataH !== 8'h77) begin failures++; $display("FAIL rmid_pre got busy=%b data=%h expected 1 77", busyH, xmit_dataH); end
    sys_rstH = 1'b1;
    tick();
    sys_rstH = 1'b0; mReq0 = 1'b0;
    checks++; if ({busyH, xmitH, ack0H, ack1H, err0H, err1H} !== 6'b0 || xmit_dataH !== 8'h00) begin
      failures++; $display("FAIL rmid_reset got flags=%b data=%h expected 000000 00", {busyH, xmitH, ack0H, ack1H, err0H, err1H}, xmit_dataH);
    end
    mDone = 1'b1;
    tick();
    mDone = 1'b0;
    checks++; if ({ack0H, ack1H, busyH} !== 3'b000) begin failures++; $display("FAIL rmid_done got ack/busy=%b expected 000", {ack0H, ack1H, busyH}); end
    repeat (3) tick();
    checks++; if (obsQ.size() != 0 || busyH !== 1'b0) begin failures++; $display("FAIL rmid_quiet got records=%0d busy=%b expected 0 0", obsQ.size(), busyH); end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    rec_t e, o;
    bit   ok, seen;
    int   busyCnt;
    do_reset();
    txQ1.push_back(8'hC3);
    expQ.push_back('{1'b1, 8'hC3, 1'b1, 1'b1});
    autoReq = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin tick(); seen = xmitH; end
    checks++; if (!seen) begin failures++; $display("FAIL tmo_start got no xmit expected xmit"); end
    busyCnt = 0; seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (busyH && !xmitH) busyCnt++;
      seen = err1H;
    end
    checks++; if (!seen || busyCnt != 16 || ack1H !== 1'b0) begin failures++; $display("FAIL tmo_err got err=%b busyCycles=%0d ack1=%b expected 1 16 0", seen, busyCnt, ack1H); end
    uartDelay = 3; uartAuto = 1'b1;
    txQ1.push_back(8'hC4);
    expQ.push_back('{1'b1, 8'hC4, 1'b0, 1'b1});
    wait_obs(2, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tmo_wait got %0d records expected 2", obsQ.size()); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin failures++; $display("FAIL tmo_rec got none expected %h", e); end
      else begin o = obsQ.pop_front(); if (o !== e) begin failures++; $display("FAIL tmo_rec got %h expected %h", o, e); end end
    end
  endtask

  task automatic test_done_priority();
    do_reset();
    mD0 = 8'h4D; mReq0 = 1'b1;
    tick();
    checks++; if (xmitH !== 1'b1) begin failures++; $display("FAIL prio_xmit got %b expected 1", xmitH); end
    repeat (16) tick();
    mDone = 1'b1;
    #1;
    checks++; if ({err0H, err1H} !== 2'b00) begin failures++; $display("FAIL prio_err got %b expected 00", {err0H, err1H}); end
    tick();
    mDone = 1'b0;
    checks++; if (ack0H !== 1'b1) begin failures++; $display("FAIL prio_ack got %b expected 1", ack0H); end
    mReq0 = 1'b0;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    rec_t e, o;
    bit   ok;
    int   quiet;
    do_reset();
    mD1 = 8'h3C; mReq1 = 1'b1;
    expQ.push_back('{1'b1, 8'h3C, 1'b0, 1'b1});
    repeat (2) tick();
    quiet = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (busyH && !err0H && !err1H && !ack1H) quiet++;
    end
    checks++; if (quiet != 40) begin failures++; $display("FAIL notmo_wait got %0d quiet busy cycles expected 40", quiet); end
    mDone = 1'b1;
    tick();
    mDone = 1'b0;
    checks++; if (ack1H !== 1'b1) begin failures++; $display("FAIL notmo_ack got %b expected 1", ack1H); end
    mReq1 = 1'b0;
    wait_obs(1, 5, ok);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin failures++; $display("FAIL notmo_rec got none expected %h", e); end
      else begin o = obsQ.pop_front(); if (o !== e) begin failures++; $display("FAIL notmo_rec got %h expected %h", o, e); end end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    autoReq = 1'b0; uartAuto = 1'b0; uartDelay = 3;
    mReq0 = 1'b0; mReq1 = 1'b0; mD0 = '0; mD1 = '0; mDone = 1'b0;
    sys_rstH = 1'b1;
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_data_change();
    test_reset_mid_busy();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
    test_done_priority();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
